alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Multi-cycle 16-bit arithmetic/logic unit driven by the CPU control unit through a bgn/rdy handshake.
- Operands, opcode and flags are registered.
- acc1 is the primary result, written back to X/Y by the control unit; acc2 is the secondary result.
- Flags stay valid after completion so the control unit can evaluate later BRZ/BRN/BRC/BRO branches.

Parameters:
- none (datapath fixed at 16 bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset: synchronous, active-high; clock clk
- bgn  input  1  start request; sampled only in IDLE
- opcode  input  6  instruction opcode; op = opcode[5:1]; opcode[0] (imm/reg select) ignored
- A  input  16  operand A
- B  input  16  operand B
- acc1  output  16  primary result (registered)
- acc2  output  16  secondary result (registered)
- zero  output  1  result == 0
- negative  output  1  result bit 15
- carry  output  1  carry/borrow/shifted-out bit
- overflow  output  1  signed overflow / MUL high nonzero / divide by zero
- rdy  output  1  one-cycle completion pulse

Behaviour:
- Op codes (op = opcode[5:1]):
  - ADD=1, SUB=2, LSR=3, LSL=4, RSR=5, RSL=6, MUL=7, DIV=8, MOD=9
  - AND=10, OR=11, XOR=12, NOT=13, CMP=14, TST=15, INC=16, DEC=17
  - Any other op (HLT, MOV, LDR, NOP, branches, …): no-op.
- States: IDLE, EXEC, ITER, DONE.
- Reset: state IDLE; acc1, acc2, zero, negative, carry, overflow, rdy all 0. Reset mid-operation aborts it with no rdy pulse.
- IDLE with bgn=1 at a clock edge: latch opcode, A, B.
  - MUL/DIV/MOD go to ITER.
  - All other ops go to EXEC.
- EXEC: compute result, register outputs and flags, go to DONE.
- DONE: rdy=1 for exactly one cycle, then IDLE. bgn is ignored outside IDLE.
- Latency from the bgn-sampling edge to rdy high:
  - simple ops: 2 cycles
  - MUL/DIV/MOD: 16 iteration cycles + 1 finalize + DONE = 18 cycles
- Outputs and flags hold their values until the next flag-updating op completes.
- No-op ops still produce a rdy pulse; acc1, acc2 and flags are unchanged.
- Flag result R for zero/negative is acc1, except for CMP (A−B) and TST (A&B).
- ADD: {carry, acc1} = A+B; overflow = signed overflow; acc2=0.
- SUB: acc1 = A−B; carry = borrow (A<B unsigned); overflow = signed overflow.
- INC: acc1 = A+1. DEC: acc1 = A−1. Carry/overflow as ADD/SUB with B=1.
- CMP: flags as SUB; acc1 = A (register write-back preserves the value).
- TST: flags from A&B; acc1 = A; carry=0, overflow=0.
- AND/OR/XOR: bitwise A op B. NOT: ~A. Logic ops: carry=0, overflow=0.
- LSR/LSL: logical shift of A by n = B.
  - n=0: acc1=A, carry=0.
  - n ≥ 16: acc1=0; carry = last bit shifted out, or 0 if n>16.
  - Otherwise carry = last bit shifted out.
  - overflow = 0.
- RSR/RSL: rotate A by B[3:0].
  - carry = acc1[15] (RSR) or acc1[0] (RSL) when B[3:0]≠0, else 0.
  - overflow = 0.
- MUL: unsigned shift-add, 16 iterations.
  - {acc2, acc1} = 32-bit product.
  - carry = overflow = (acc2≠0).
  - negative from acc1[15].
- DIV: unsigned restoring division, 16 iterations; acc1 = quotient, acc2 = remainder.
- MOD: same division; acc1 = remainder, acc2 = quotient.
- DIV/MOD with B=0: acc1=16'hFFFF (DIV) or A (MOD); acc2 = A (DIV) or 16'hFFFF (MOD); overflow=1, carry=0.
- Only ops 1..17 update flags.

Test Plan:
- rst=1 for 2 cycles → all outputs 0. Then ADD, A=16'h7FFF, B=1, bgn → rdy pulse 2 cycles later, one cycle wide; acc1=16'h8000, overflow=1, negative=1, carry=0.
- SUB A=3, B=5 → acc1=16'hFFFE, carry=1, negative=1. Then CMP A=9, B=9 → acc1=9, zero=1. Then NOP → rdy pulse, flags still zero=1.
- MUL A=16'h1234, B=16'h0100 → rdy 18 cycles after the bgn edge; acc1=16'h3400, acc2=16'h0012, carry=overflow=1.
- DIV A=100, B=7 → acc1=14, acc2=2. MOD same operands → acc1=2, acc2=14. DIV A=5, B=0 → acc1=16'hFFFF, acc2=5, overflow=1.
- LSL A=16'h8001, B=1 → acc1=16'h0002, carry=1. RSR A=16'h0001, B=1 → acc1=16'h8000, carry=1. LSR A=16'hFFFF, B=20 → acc1=0, zero=1.
- Assert rst during MUL iteration 8 → no rdy, outputs 0. A new ADD A=2, B=2 then completes with acc1=4.

Source files
------------

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - multi-cycle 16-bit ALU with bgn/rdy handshake and sticky flags
//
// Ports:
//   clk       clock, all state updates on rising edge
//   rst       synchronous active-high reset; aborts any operation in flight
//   bgn       start request, sampled only while idle
//   opcode    instruction opcode; op = opcode[5:1], opcode[0] ignored
//   A, B      operands, latched when an operation starts
//   acc1      primary result (written back to X/Y by the control unit)
//   acc2      secondary result (MUL high half, DIV remainder, MOD quotient)
//   zero      flag result == 0
//   negative  flag result bit 15
//   carry     carry / borrow / last bit shifted out
//   overflow  signed overflow / MUL high half nonzero / divide by zero
//   rdy       one-cycle completion pulse
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        bgn,
    input  logic [5:0]  opcode,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] acc1,
    output logic [15:0] acc2,
    output logic        zero,
    output logic        negative,
    output logic        carry,
    output logic        overflow,
    output logic        rdy
);

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_LSR = 5'd3;
    localparam logic [4:0] OP_LSL = 5'd4;
    localparam logic [4:0] OP_RSR = 5'd5;
    localparam logic [4:0] OP_RSL = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_DIV = 5'd8;
    localparam logic [4:0] OP_MOD = 5'd9;
    localparam logic [4:0] OP_AND = 5'd10;
    localparam logic [4:0] OP_OR  = 5'd11;
    localparam logic [4:0] OP_XOR = 5'd12;
    localparam logic [4:0] OP_NOT = 5'd13;
    localparam logic [4:0] OP_CMP = 5'd14;
    localparam logic [4:0] OP_TST = 5'd15;
    localparam logic [4:0] OP_INC = 5'd16;
    localparam logic [4:0] OP_DEC = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

    state_t      state;
    logic [4:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] hi;        // MUL: running high half; DIV/MOD: partial remainder
    logic [15:0] lo;        // MUL: multiplier shifting out / product low; DIV/MOD: dividend -> quotient
    logic [4:0]  iter_cnt;

    logic [4:0]  op_in;
    logic        unused_imm;

    assign op_in      = opcode[5:1];
    assign unused_imm = opcode[0];

    // Single-cycle ops, evaluated from the latched operands while in EXEC.
    logic [15:0] addend, subend;
    logic [16:0] sum, diff;
    logic [3:0]  lsr_idx, lsl_idx, rot;
    logic        sh_hit;
    logic [15:0] s_res, s_flag;
    logic        s_c, s_v, s_upd;

    always_comb begin
        addend  = (op_q == OP_INC) ? 16'd1 : b_q;
        subend  = (op_q == OP_DEC) ? 16'd1 : b_q;
        sum     = {1'b0, a_q} + {1'b0, addend};
        diff    = {1'b0, a_q} - {1'b0, subend};
        // Index of the last bit to leave the word for a shift of 1..16.
        lsr_idx = b_q[3:0] - 4'd1;
        lsl_idx = 4'd0 - b_q[3:0];
        sh_hit  = (b_q != 16'd0) && (b_q <= 16'd16);
        rot     = b_q[3:0];

        s_res  = 16'h0;
        s_flag = 16'h0;
        s_c    = 1'b0;
        s_v    = 1'b0;
        s_upd  = 1'b1;
        case (op_q)
            OP_ADD, OP_INC: begin
                s_res = sum[15:0];
                s_c   = sum[16];
                s_v   = (a_q[15] == addend[15]) && (sum[15] != a_q[15]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                // CMP keeps A so the register write-back is harmless.
                s_res  = (op_q == OP_CMP) ? a_q : diff[15:0];
                s_flag = diff[15:0];
                s_c    = diff[16];
                s_v    = (a_q[15] != subend[15]) && (diff[15] != a_q[15]);
            end
            OP_LSR: begin
                s_res = a_q >> b_q;
                s_c   = sh_hit ? a_q[lsr_idx] : 1'b0;
            end
            OP_LSL: begin
                s_res = a_q << b_q;
                s_c   = sh_hit ? a_q[lsl_idx] : 1'b0;
            end
            OP_RSR: begin
                s_res = (a_q >> rot) | (a_q << (5'd16 - {1'b0, rot}));
                s_c   = (rot != 4'd0) && s_res[15];
            end
            OP_RSL: begin
                s_res = (a_q << rot) | (a_q >> (5'd16 - {1'b0, rot}));
                s_c   = (rot != 4'd0) && s_res[0];
            end
            OP_AND:  s_res = a_q & b_q;
            OP_OR:   s_res = a_q | b_q;
            OP_XOR:  s_res = a_q ^ b_q;
            OP_NOT:  s_res = ~a_q;
            OP_TST: begin
                s_res  = a_q;
                s_flag = a_q & b_q;
            end
            default: s_upd = 1'b0;
        endcase
        if (op_q != OP_CMP && op_q != OP_TST) begin
            s_flag = s_res;
        end
    end

    // One shift-add / restore-subtract step per ITER cycle.
    logic [16:0] mul_sum;
    logic [16:0] div_t;
    logic        div_ge;
    logic [15:0] div_sub;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : 17'd0);
        div_t   = {hi, lo[15]};
        div_ge  = div_t >= {1'b0, b_q};
        // Remainder after a successful subtract is below B, so 16 bits suffice.
        div_sub = div_t[15:0] - b_q;
    end

    // Result selection after the 16th step, including divide-by-zero.
    logic [15:0] f_acc1, f_acc2;
    logic        f_c, f_v;

    always_comb begin
        f_acc1 = lo;
        f_acc2 = hi;
        f_c    = 1'b0;
        f_v    = 1'b0;
        case (op_q)
            OP_MUL: begin
                f_c = (hi != 16'h0);
                f_v = (hi != 16'h0);
            end
            OP_DIV: begin
                if (b_q == 16'h0) begin
                    f_acc1 = 16'hFFFF;
                    f_acc2 = a_q;
                    f_v    = 1'b1;
                end
            end
            OP_MOD: begin
                if (b_q == 16'h0) begin
                    f_acc1 = a_q;
                    f_acc2 = 16'hFFFF;
                    f_v    = 1'b1;
                end else begin
                    f_acc1 = hi;
                    f_acc2 = lo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= 5'd0;
            a_q      <= 16'h0;
            b_q      <= 16'h0;
            hi       <= 16'h0;
            lo       <= 16'h0;
            iter_cnt <= 5'd0;
            acc1     <= 16'h0;
            acc2     <= 16'h0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rdy <= 1'b0;
                    if (bgn) begin
                        op_q     <= op_in;
                        a_q      <= A;
                        b_q      <= B;
                        hi       <= 16'h0;
                        lo       <= (op_in == OP_MUL) ? B : A;
                        iter_cnt <= 5'd0;
                        if (op_in == OP_MUL || op_in == OP_DIV || op_in == OP_MOD) begin
                            state <= S_ITER;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (s_upd) begin
                        acc1     <= s_res;
                        acc2     <= 16'h0;
                        zero     <= (s_flag == 16'h0);
                        negative <= s_flag[15];
                        carry    <= s_c;
                        overflow <= s_v;
                    end
                    state <= S_DONE;
                end
                S_ITER: begin
                    if (iter_cnt != 5'd16) begin
                        if (op_q == OP_MUL) begin
                            hi <= mul_sum[16:1];
                            lo <= {mul_sum[0], lo[15:1]};
                        end else begin
                            hi <= div_ge ? div_sub : div_t[15:0];
                            lo <= {lo[14:0], div_ge};
                        end
                        iter_cnt <= iter_cnt + 5'd1;
                    end else begin
                        acc1     <= f_acc1;
                        acc2     <= f_acc2;
                        zero     <= (f_acc1 == 16'h0);
                        negative <= f_acc1[15];
                        carry    <= f_c;
                        overflow <= f_v;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    rdy   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        bgn;
    logic [5:0]  opcode;
    logic [15:0] A, B;
    logic [15:0] acc1, acc2;
    logic        zero, negative, carry, overflow, rdy;

    alu_unit dut (
        .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .A(A), .B(B),
        .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .rdy(rdy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({zero, negative, carry, overflow});
    endfunction

    // Start one op and return cycles from the bgn-sampling edge to rdy.
    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat);
        @(negedge clk);
        opcode = {op, 1'($urandom_range(0, 1))};
        A = a;
        B = b;
        bgn = 1'b1;
        @(posedge clk);
        #1;
        bgn = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rdy) break;
        end
        if (lat < 40) begin
            @(negedge clk);
            chk("rdy_width", 32'(rdy), 32'd0);
        end
    endtask

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [15:0] a, b, e1, e2;
        bit          chk2;
        logic [3:0]  fl;   // {zero, negative, carry, overflow}
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] acc1, acc2;
        logic [3:0]  fl;
        bit          upd, a2;
        int          lat;
    } res_t;

    // Reference: plain integer arithmetic and bit-at-a-time shifting.
    function automatic res_t model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        int          s, sv, k;
        logic [15:0] bb, x, rf;
        logic [31:0] p;
        logic        c, v;
        r.upd = 1'b1; r.a2 = 1'b0; r.acc1 = 16'h0; r.acc2 = 16'h0;
        c = 1'b0; v = 1'b0; rf = 16'h0;
        r.lat = (op >= 5'd7 && op <= 5'd9) ? 18 : 2;
        case (op)
            5'd1, 5'd16: begin
                bb = (op == 5'd1) ? b : 16'd1;
                s  = int'(a) + int'(bb);
                r.acc1 = s[15:0];
                c  = s > 65535;
                sv = int'($signed(a)) + int'($signed(bb));
                v  = sv > 32767 || sv < -32768;
                if (op == 5'd1) r.a2 = 1'b1;
            end
            5'd2, 5'd17, 5'd14: begin
                bb = (op == 5'd17) ? 16'd1 : b;
                s  = int'(a) - int'(bb);
                rf = s[15:0];
                c  = s < 0;
                sv = int'($signed(a)) - int'($signed(bb));
                v  = sv > 32767 || sv < -32768;
                r.acc1 = (op == 5'd14) ? a : rf;
            end
            5'd3, 5'd4: begin
                x = a;
                k = (b > 16'd17) ? 17 : int'(b);
                for (int i = 0; i < k; i++) begin
                    if (op == 5'd3) begin c = x[0];  x = x >> 1; end
                    else            begin c = x[15]; x = x << 1; end
                end
                r.acc1 = x;
            end
            5'd5, 5'd6: begin
                x = a;
                k = int'(b[3:0]);
                for (int i = 0; i < k; i++) begin
                    if (op == 5'd5) x = {x[0], x[15:1]};
                    else            x = {x[14:0], x[15]};
                end
                r.acc1 = x;
                c = (k != 0) ? ((op == 5'd5) ? x[15] : x[0]) : 1'b0;
            end
            5'd7: begin
                p = 32'(a) * 32'(b);
                r.acc1 = p[15:0];
                r.acc2 = p[31:16];
                c = (r.acc2 != 16'h0);
                v = c;
                r.a2 = 1'b1;
            end
            5'd8, 5'd9: begin
                r.a2 = 1'b1;
                if (b == 16'h0) begin
                    r.acc1 = (op == 5'd8) ? 16'hFFFF : a;
                    r.acc2 = (op == 5'd8) ? a : 16'hFFFF;
                    v = 1'b1;
                end else begin
                    r.acc1 = (op == 5'd8) ? a / b : a % b;
                    r.acc2 = (op == 5'd8) ? a % b : a / b;
                end
            end
            5'd10: r.acc1 = a & b;
            5'd11: r.acc1 = a | b;
            5'd12: r.acc1 = a ^ b;
            5'd13: r.acc1 = ~a;
            5'd15: begin r.acc1 = a; rf = a & b; end
            default: r.upd = 1'b0;
        endcase
        if (op != 5'd14 && op != 5'd15) rf = r.acc1;
        r.fl = {rf == 16'h0, rf[15], c, v};
        return r;
    endfunction

    vec_t tbl[20];

    initial begin
        int          lat;
        bit          seen;
        res_t        ex;
        logic [15:0] m1, m2;
        logic [3:0]  mfl;
        bit          m2k;
        logic [4:0]  rop;
        logic [15:0] ra, rb;

        tbl[0]  = '{"add_ovf",  5'd1,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1, 4'b0101, 2};
        tbl[1]  = '{"sub_brw",  5'd2,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 0, 4'b0110, 2};
        tbl[2]  = '{"cmp_eq",   5'd14, 16'h0009, 16'h0009, 16'h0009, 16'h0000, 0, 4'b1000, 2};
        tbl[3]  = '{"nop_hold", 5'd0,  16'h1111, 16'h2222, 16'h0009, 16'h0000, 0, 4'b1000, 2};
        tbl[4]  = '{"mul",      5'd7,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 4'b0011, 18};
        tbl[5]  = '{"div",      5'd8,  16'd100,  16'd7,    16'd14,   16'd2,    1, 4'b0000, 18};
        tbl[6]  = '{"mod",      5'd9,  16'd100,  16'd7,    16'd2,    16'd14,   1, 4'b0000, 18};
        tbl[7]  = '{"div_z",    5'd8,  16'd5,    16'd0,    16'hFFFF, 16'd5,    1, 4'b0101, 18};
        tbl[8]  = '{"lsl1",     5'd4,  16'h8001, 16'd1,    16'h0002, 16'h0000, 0, 4'b0010, 2};
        tbl[9]  = '{"rsr1",     5'd5,  16'h0001, 16'd1,    16'h8000, 16'h0000, 0, 4'b0110, 2};
        tbl[10] = '{"lsr20",    5'd3,  16'hFFFF, 16'd20,   16'h0000, 16'h0000, 0, 4'b1000, 2};
        tbl[11] = '{"lsr16",    5'd3,  16'h8000, 16'd16,   16'h0000, 16'h0000, 0, 4'b1010, 2};
        tbl[12] = '{"lsl16",    5'd4,  16'h0001, 16'd16,   16'h0000, 16'h0000, 0, 4'b1010, 2};
        tbl[13] = '{"inc_wrap", 5'd16, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 0, 4'b1010, 2};
        tbl[14] = '{"dec_ovf",  5'd17, 16'h8000, 16'h1234, 16'h7FFF, 16'h0000, 0, 4'b0001, 2};
        tbl[15] = '{"tst",      5'd15, 16'h00F0, 16'h0F00, 16'h00F0, 16'h0000, 0, 4'b1000, 2};
        tbl[16] = '{"mod_z",    5'd9,  16'd5,    16'd0,    16'd5,    16'hFFFF, 1, 4'b0001, 18};
        tbl[17] = '{"rsl1",     5'd6,  16'h8000, 16'd1,    16'h0001, 16'h0000, 0, 4'b0010, 2};
        tbl[18] = '{"hlt_hold", 5'd31, 16'hAAAA, 16'h5555, 16'h0001, 16'h0000, 0, 4'b0010, 2};
        tbl[19] = '{"lsr0",     5'd3,  16'h1234, 16'd0,    16'h1234, 16'h0000, 0, 4'b0000, 2};

        rst = 1'b1; bgn = 1'b0; opcode = 6'h0; A = 16'h0; B = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_acc1",  32'(acc1), 32'd0);
        chk("reset_acc2",  32'(acc2), 32'd0);
        chk("reset_flags", flags(),   32'd0);
        chk("reset_rdy",   32'(rdy),  32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            chk({tbl[i].name, "_lat"},   32'(lat),       32'(tbl[i].lat));
            chk({tbl[i].name, "_acc1"},  32'(acc1),      32'(tbl[i].e1));
            chk({tbl[i].name, "_flags"}, flags(),        32'(tbl[i].fl));
            if (tbl[i].chk2) chk({tbl[i].name, "_acc2"}, 32'(acc2), 32'(tbl[i].e2));
        end

        // Reset during MUL iteration 8 aborts without a completion pulse.
        @(negedge clk);
        opcode = {5'd7, 1'b0}; A = 16'h1234; B = 16'h0100; bgn = 1'b1;
        @(posedge clk);
        #1 bgn = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rdy) seen = 1'b1;
        end
        chk("abort_no_rdy", 32'(seen),  32'd0);
        chk("abort_acc1",   32'(acc1),  32'd0);
        chk("abort_acc2",   32'(acc2),  32'd0);
        chk("abort_flags",  flags(),    32'd0);
        run_op(5'd1, 16'd2, 16'd2, lat);
        chk("post_abort_lat",  32'(lat),  32'd2);
        chk("post_abort_acc1", 32'(acc1), 32'd4);

        // Randomized run against the model, starting from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m1 = 16'h0; m2 = 16'h0; mfl = 4'h0; m2k = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(0, 20));
                1:       rb = 16'h0;
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 16'h8000;
            ex = model(rop, ra, rb);
            if (ex.upd) begin
                m1  = ex.acc1;
                mfl = ex.fl;
                m2k = ex.a2;
                m2  = ex.acc2;
            end
            run_op(rop, ra, rb, lat);
            chk($sformatf("rnd%0d_op%0d_lat", n, rop),   32'(lat),  32'(ex.lat));
            chk($sformatf("rnd%0d_op%0d_acc1", n, rop),  32'(acc1), 32'(m1));
            chk($sformatf("rnd%0d_op%0d_flags", n, rop), flags(),   32'(mfl));
            if (m2k) chk($sformatf("rnd%0d_op%0d_acc2", n, rop), 32'(acc2), 32'(m2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
